uart_tx_arbiter: RTL and testbench

Shares the single UART transmitter between two byte sources. Client 0 is the command response path (OK/ERR/query text), a pulse-style start/busy requester. Client 1 is the cipher output stream (enciphered letters), a valid/ready requester buffered by an internal FIFO. The block sits between fsm_controller's response path, the cipher output stage and uart_tx. It has strict response priority and a lock so multi-line responses are never interleaved with cipher bytes.

---
 rtl/enigma_pkg.sv | 17 +
 rtl/uart_tx_arbiter_if.sv | 32 +++
 rtl/uart_tx_arbiter_byte_fifo.sv | 49 ++++
 rtl/uart_tx_arbiter.sv | 131 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/enigma_pkg.sv
// Shared constants for the UART transmit arbiter.
// State encodings, timeout default and ASCII line-ending bytes.
package enigma_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t S_IDLE     = 2'd0;
    localparam arb_state_t S_LAUNCH   = 2'd1;
    localparam arb_state_t S_WAIT_ACK = 2'd2;
    localparam arb_state_t S_DRAIN    = 2'd3;

    localparam int ACK_TIMEOUT_DEF = 4;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Client and uart_tx handshake bundle for the transmit arbiter.
// master = clients plus uart_tx side, slave = arbiter side.
interface uart_tx_arbiter_if;

    logic       c0_start;
    logic [7:0] c0_byte;
    logic       c0_lock;
    logic       c0_busy;
    logic       c1_valid;
    logic [7:0] c1_byte;
    logic       c1_ready;
    logic       tx_busy;
    logic [7:0] tx_byte;
    logic       tx_start;

    modport master (
        output c0_start, c0_byte, c0_lock,
        output c1_valid, c1_byte,
        output tx_busy,
        input  c0_busy, c1_ready,
        input  tx_byte, tx_start
    );

    modport slave (
        input  c0_start, c0_byte, c0_lock,
        input  c1_valid, c1_byte,
        input  tx_busy,
        output c0_busy, c1_ready,
        output tx_byte, tx_start
    );

endinterface

// File: rtl/uart_tx_arbiter_byte_fifo.sv
// Byte FIFO with first-word-fall-through output.
// Pointers carry an extra wrap bit so count reaches DEPTH.
module byte_fifo #(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic [AW:0] count,
    output logic        full,
    output logic        empty
);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (wr_ptr == rd_ptr);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // storage write, no reset needed on the data array
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    // pointer update; full blocks push, empty blocks pop
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between the response path (c0) and the
// cipher stream (c1, FIFO-buffered); c0 wins, c0_lock holds c1 off.
module uart_tx_arbiter
    import enigma_pkg::*;
#(
    parameter  int FIFO_DEPTH  = 8,
    parameter  int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
    localparam int CW          = $clog2(FIFO_DEPTH) + 1,
    localparam int TW          = $clog2(ACK_TIMEOUT + 1)
) (
    input  logic                clk,
    input  logic                rst,
    uart_tx_arbiter_if.slave    bus,
    output logic [CW-1:0]       fifo_count,
    input  logic                clear_err,
    output logic                overflow,
    output logic                proto_err
);

    arb_state_t  state;
    logic [TW-1:0] ack_cnt;
    logic [7:0]  tx_byte_q;

    logic        c0_buf_valid;
    logic [7:0]  c0_buf;

    logic        f_push;
    logic        f_full;
    logic        f_empty;
    logic [7:0]  f_dout;

    logic        idle_free;
    logic        issue_c0;
    logic        issue_c1;
    logic        ovf_evt;
    logic        proto_evt;

    assign idle_free = (state == S_IDLE) && !bus.tx_busy;
    assign issue_c0  = idle_free && c0_buf_valid;
    assign issue_c1  = idle_free && !c0_buf_valid
                    && !bus.c0_lock && !f_empty;

    assign bus.c1_ready = !f_full;
    assign f_push       = bus.c1_valid && !f_full;
    assign ovf_evt      = bus.c1_valid && f_full;
    assign proto_evt    = bus.c0_start && c0_buf_valid;

    assign bus.c0_busy  = bus.c0_start | c0_buf_valid
                        | (state != S_IDLE) | bus.tx_busy;
    assign bus.tx_start = (state == S_LAUNCH);
    assign bus.tx_byte  = tx_byte_q;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (f_push),
        .pop   (issue_c1),
        .din   (bus.c1_byte),
        .dout  (f_dout),
        .count (fifo_count),
        .full  (f_full),
        .empty (f_empty)
    );

    // c0 holding register: capture when empty, release on issue
    always_ff @(posedge clk) begin
        if (rst) begin
            c0_buf_valid <= 1'b0;
            c0_buf       <= 8'h00;
        end else if (bus.c0_start && !c0_buf_valid) begin
            c0_buf_valid <= 1'b1;
            c0_buf       <= bus.c0_byte;
        end else if (issue_c0) begin
            c0_buf_valid <= 1'b0;
        end
    end

    // launch sequencer; WAIT_ACK gives up after ACK_TIMEOUT cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            tx_byte_q <= 8'h00;
            ack_cnt   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (issue_c0) begin
                        tx_byte_q <= c0_buf;
                        state     <= S_LAUNCH;
                    end else if (issue_c1) begin
                        tx_byte_q <= f_dout;
                        state     <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    ack_cnt <= '0;
                    state   <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (bus.tx_busy) begin
                        state <= S_DRAIN;
                    end else if (ack_cnt == TW'(ACK_TIMEOUT - 1)) begin
                        state <= S_IDLE;
                    end else begin
                        ack_cnt <= ack_cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (!bus.tx_busy) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // sticky error flags; a set event beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            overflow  <= ovf_evt   | (overflow  & ~clear_err);
            proto_err <= proto_evt | (proto_err & ~clear_err);
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter.
// Clients and a simple uart_tx busy model drive the bus.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    import enigma_pkg::*;

    localparam int DEPTH    = 8;
    localparam int ACK_TO   = 4;
    localparam int BUSY_LEN = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear_err = 1'b0;
    logic [3:0] fifo_count;
    logic       overflow;
    logic       proto_err;
    logic       uart_busy = 1'b0;

    uart_tx_arbiter_if bus ();

    assign bus.tx_busy = uart_busy;

    uart_tx_arbiter #(
        .FIFO_DEPTH  (DEPTH),
        .ACK_TIMEOUT (ACK_TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .fifo_count (fifo_count),
        .clear_err  (clear_err),
        .overflow   (overflow),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int uart_mode = 0;  // 0 normal, 1 stalled busy, 2 never busy
    int busy_left = 0;
    logic [7:0] launched [$];
    int         launch_cyc [$];

    always @(posedge clk) cyc <= cyc + 1;

    // monitor launches and model uart_tx busy behaviour
    always @(negedge clk) begin
        if (bus.tx_start === 1'b1) begin
            launched.push_back(bus.tx_byte);
            launch_cyc.push_back(cyc);
        end
        if (rst) busy_left = 0;
        else if (bus.tx_start === 1'b1) busy_left = BUSY_LEN;
        else if (busy_left > 0) busy_left--;
        case (uart_mode)
            1:       uart_busy = 1'b1;
            2:       uart_busy = 1'b0;
            default: uart_busy = (busy_left > 0);
        endcase
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_log();
        launched.delete();
        launch_cyc.delete();
    endtask

    task automatic settle(output bit ok);
        int n = 0;
        while ((bus.c0_busy || fifo_count != 0) && n < 400) begin
            step();
            n++;
        end
        ok = (n < 400);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(2);
        total++; if (bus.tx_start !== 1'b0) begin bad++; $display("FAIL rst_tx_start: got %b want 0", bus.tx_start); end
        total++; if (bus.tx_byte !== 8'h00) begin bad++; $display("FAIL rst_tx_byte: got %h want 00", bus.tx_byte); end
        total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
        total++; if (overflow !== 1'b0 || proto_err !== 1'b0) begin bad++; $display("FAIL rst_flags: got %b%b want 00", overflow, proto_err); end
        total++; if (bus.c1_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", bus.c1_ready); end
        total++; if (bus.c0_busy !== 1'b0) begin bad++; $display("FAIL rst_c0_busy: got %b want 0", bus.c0_busy); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_c0_response();
        logic [7:0] msg [4];
        int t0 = 0;
        int n;
        msg[0] = 8'h4F; msg[1] = 8'h4B; msg[2] = ASCII_CR; msg[3] = ASCII_LF;
        uart_mode = 0;
        clear_log();
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (bus.c0_busy && n < 100) begin step(); n++; end
            bus.c0_byte  = msg[i];
            bus.c0_start = 1'b1;
            if (i == 0) t0 = cyc;
            step();
            bus.c0_start = 1'b0;
            n = 0;
            while (bus.c0_busy && n < 100) begin step(); n++; end
            total++;
            if (launched.size() != i + 1 || uart_busy) begin
                bad++;
                $display("FAIL c0_busy_span[%0d]: got launches=%0d busy=%b want %0d,0", i, launched.size(), uart_busy, i + 1);
            end
        end
        total++; if (launched.size() != 4) begin bad++; $display("FAIL c0_count: got %0d want 4", launched.size()); end
        for (int i = 0; i < 4; i++) begin
            total++; if (launched[i] !== msg[i]) begin bad++; $display("FAIL c0_byte[%0d]: got %h want %h", i, launched[i], msg[i]); end
        end
        total++; if (launch_cyc[0] != t0 + 2) begin bad++; $display("FAIL c0_latency: got %0d want %0d", launch_cyc[0], t0 + 2); end
        total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL c0_proto: got %b want 0", proto_err); end
    endtask

    task automatic test_lock();
        logic [7:0] q [3];
        bit ok;
        int n = 0;
        q[0] = 8'h51; q[1] = 8'h57; q[2] = 8'h45;
        settle(ok);
        total++; if (!ok) begin bad++; $display("FAIL lock_settle: got timeout want idle"); end
        clear_log();
        bus.c0_lock = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            bus.c1_valid = 1'b1;
            bus.c1_byte  = q[i];
            step();
        end
        bus.c1_valid = 1'b0;
        step(10);
        total++; if (launched.size() != 0) begin bad++; $display("FAIL lock_hold: got %0d launches want 0", launched.size()); end
        total++; if (fifo_count !== 4'd3) begin bad++; $display("FAIL lock_count: got %0d want 3", fifo_count); end
        bus.c0_lock = 1'b0;
        while (launched.size() < 3 && n < 200) begin step(); n++; end
        total++; if (launched.size() != 3) begin bad++; $display("FAIL lock_drain: got %0d want 3", launched.size()); end
        for (int i = 0; i < 3; i++) begin
            total++; if (launched[i] !== q[i]) begin bad++; $display("FAIL lock_byte[%0d]: got %h want %h", i, launched[i], q[i]); end
        end
    endtask

    task automatic test_same_cycle();
        bit ok;
        int n = 0;
        settle(ok);
        total++; if (!ok) begin bad++; $display("FAIL same_settle: got timeout want idle"); end
        clear_log();
        bus.c0_start = 1'b1; bus.c0_byte = 8'h21;
        bus.c1_valid = 1'b1; bus.c1_byte = 8'hA5;
        step();
        bus.c0_start = 1'b0; bus.c1_valid = 1'b0;
        while (launched.size() < 2 && n < 100) begin step(); n++; end
        total++; if (launched.size() != 2) begin bad++; $display("FAIL same_count: got %0d want 2", launched.size()); end
        total++; if (launched[0] !== 8'h21 || launched[1] !== 8'hA5) begin bad++; $display("FAIL same_order: got %h,%h want 21,a5", launched[0], launched[1]); end
        total++; if (launch_cyc[1] <= launch_cyc[0] + BUSY_LEN) begin bad++; $display("FAIL same_gap: got %0d want >%0d", launch_cyc[1] - launch_cyc[0], BUSY_LEN); end
    endtask

    task automatic test_overflow();
        bit ok;
        int n = 0;
        settle(ok);
        total++; if (!ok) begin bad++; $display("FAIL ovf_settle: got timeout want idle"); end
        clear_log();
        uart_mode = 1;
        step();
        bus.c0_byte = 8'h31; bus.c0_start = 1'b1;
        step();
        bus.c0_byte = 8'h32;
        step();
        bus.c0_start = 1'b0;
        total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL proto_set: got %b want 1", proto_err); end
        for (int i = 0; i < 9; i++) begin
            total++; if (bus.c1_ready !== (i < DEPTH)) begin bad++; $display("FAIL ovf_ready[%0d]: got %b want %b", i, bus.c1_ready, i < DEPTH); end
            bus.c1_valid = 1'b1;
            bus.c1_byte  = 8'hC0 + 8'(i);
            clear_err    = (i == 8);
            step();
        end
        bus.c1_valid = 1'b0;
        clear_err    = 1'b0;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set_wins: got %b want 1", overflow); end
        total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL proto_clear: got %b want 0", proto_err); end
        total++; if (fifo_count !== 4'd8) begin bad++; $display("FAIL ovf_count: got %0d want 8", fifo_count); end
        total++; if (launched.size() != 0) begin bad++; $display("FAIL ovf_stall: got %0d launches want 0", launched.size()); end
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", overflow); end
        uart_mode = 0;
        while (launched.size() < 9 && n < 400) begin step(); n++; end
        step(20);
        total++; if (launched.size() != 9) begin bad++; $display("FAIL ovf_drain: got %0d want 9", launched.size()); end
        total++; if (launched[0] !== 8'h31) begin bad++; $display("FAIL ovf_c0_first: got %h want 31", launched[0]); end
        for (int i = 0; i < 8; i++) begin
            total++; if (launched[i+1] !== 8'hC0 + 8'(i)) begin bad++; $display("FAIL ovf_byte[%0d]: got %h want %h", i, launched[i+1], 8'hC0 + 8'(i)); end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int n = 0;
        int t0;
        settle(ok);
        total++; if (!ok) begin bad++; $display("FAIL to_settle: got timeout want idle"); end
        clear_log();
        uart_mode = 2;
        t0 = cyc;
        bus.c1_valid = 1'b1; bus.c1_byte = 8'hD1;
        step();
        bus.c1_byte = 8'hD2;
        step();
        bus.c1_valid = 1'b0;
        while (launched.size() < 2 && n < 100) begin step(); n++; end
        total++; if (launched.size() != 2) begin bad++; $display("FAIL to_count: got %0d want 2", launched.size()); end
        total++; if (launched[0] !== 8'hD1 || launched[1] !== 8'hD2) begin bad++; $display("FAIL to_order: got %h,%h want d1,d2", launched[0], launched[1]); end
        total++; if (launch_cyc[0] != t0 + 2) begin bad++; $display("FAIL c1_latency: got %0d want %0d", launch_cyc[0], t0 + 2); end
        total++; if (launch_cyc[1] - launch_cyc[0] != ACK_TO + 2) begin bad++; $display("FAIL to_gap: got %0d want %0d", launch_cyc[1] - launch_cyc[0], ACK_TO + 2); end
        uart_mode = 0;
    endtask

    task automatic test_reset_drain();
        bit ok;
        int n = 0;
        settle(ok);
        total++; if (!ok) begin bad++; $display("FAIL rd_settle: got timeout want idle"); end
        clear_log();
        for (int i = 0; i < 4; i++) begin
            bus.c1_valid = 1'b1;
            bus.c1_byte  = 8'hE1 + 8'(i);
            step();
        end
        bus.c1_valid = 1'b0;
        while (launched.size() < 1 && n < 50) begin step(); n++; end
        step(3);
        total++; if (dut.state !== S_DRAIN || fifo_count !== 4'd3) begin bad++; $display("FAIL rd_pre: got state=%0d count=%0d want 3,3", dut.state, fifo_count); end
        rst = 1'b1;
        step();
        total++; if (bus.tx_start !== 1'b0) begin bad++; $display("FAIL rd_tx_start: got %b want 0", bus.tx_start); end
        total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL rd_count: got %0d want 0", fifo_count); end
        total++; if (bus.c1_ready !== 1'b1) begin bad++; $display("FAIL rd_ready: got %b want 1", bus.c1_ready); end
        total++; if (dut.state !== S_IDLE) begin bad++; $display("FAIL rd_state: got %0d want %0d", dut.state, S_IDLE); end
        rst = 1'b0;
        step(60);
        total++; if (launched.size() != 1) begin bad++; $display("FAIL rd_stale: got %0d launches want 1", launched.size()); end
    endtask

    task automatic test_random();
        logic [7:0] sent0 [$];
        logic [7:0] sent1 [$];
        logic [7:0] got0 [$];
        logic [7:0] got1 [$];
        bit ok;
        int to0 = 0;
        int to1 = 0;
        int n = 0;
        int errs;
        settle(ok);
        total++; if (!ok) begin bad++; $display("FAIL rnd_settle: got timeout want idle"); end
        clear_log();
        fork
            begin
                for (int k = 0; k < 15; k++) begin
                    int w = 0;
                    step(int'($urandom_range(0, 8)));
                    while (bus.c0_busy && w < 400) begin step(); w++; end
                    if (w >= 400) to0++;
                    bus.c0_byte  = 8'($urandom_range(0, 127));
                    bus.c0_start = 1'b1;
                    sent0.push_back(bus.c0_byte);
                    step();
                    bus.c0_start = 1'b0;
                end
            end
            begin
                for (int k = 0; k < 25; k++) begin
                    int w = 0;
                    step(int'($urandom_range(0, 3)));
                    while (!bus.c1_ready && w < 400) begin step(); w++; end
                    if (w >= 400) to1++;
                    bus.c1_valid = 1'b1;
                    bus.c1_byte  = 8'h80 | 8'($urandom_range(0, 127));
                    sent1.push_back(bus.c1_byte);
                    step();
                    bus.c1_valid = 1'b0;
                end
            end
        join
        total++; if (to0 != 0 || to1 != 0) begin bad++; $display("FAIL rnd_client_wait: got %0d,%0d timeouts want 0,0", to0, to1); end
        while (launched.size() < 40 && n < 1500) begin step(); n++; end
        foreach (launched[i]) begin
            if (launched[i][7]) got1.push_back(launched[i]);
            else got0.push_back(launched[i]);
        end
        total++; if (got0.size() != sent0.size()) begin bad++; $display("FAIL rnd_c0_count: got %0d want %0d", got0.size(), sent0.size()); end
        total++; if (got1.size() != sent1.size()) begin bad++; $display("FAIL rnd_c1_count: got %0d want %0d", got1.size(), sent1.size()); end
        errs = 0;
        foreach (sent0[i]) if (got0[i] !== sent0[i]) errs++;
        total++; if (errs != 0) begin bad++; $display("FAIL rnd_c0_order: got %0d mismatched bytes want 0", errs); end
        errs = 0;
        foreach (sent1[i]) if (got1[i] !== sent1[i]) errs++;
        total++; if (errs != 0) begin bad++; $display("FAIL rnd_c1_order: got %0d mismatched bytes want 0", errs); end
        total++; if (overflow !== 1'b0 || proto_err !== 1'b0) begin bad++; $display("FAIL rnd_flags: got %b%b want 00", overflow, proto_err); end
    endtask

    initial begin
        bus.c0_start = 1'b0;
        bus.c0_byte  = 8'h00;
        bus.c0_lock  = 1'b0;
        bus.c1_valid = 1'b0;
        bus.c1_byte  = 8'h00;
        test_reset();
        test_c0_response();
        test_lock();
        test_same_cycle();
        test_overflow();
        test_timeout();
        test_reset_drain();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule
